imem_boot_bist_sequencer: RTL and testbench
===========================================

Name: imem_boot_bist_sequencer

Overview:
- Power-on controller that sequences the 5-stage ECC pipeline core.
- Streams a program image into instruction memory over the imem write port, then runs a BIST window with test_en high on the hardened muxes and ALU, checks the fault flags, and releases the core from reset.
- Sits between the SoC boot source and the pipeline top. It is the sole driver of the core's rst, imem_we/imem_waddr/imem_wdata, loader_done_in and test_en_in inputs.

Parameters:
PROG_WORDS, 64, number of 32-bit instruction words loaded (>=1)
BIST_CYCLES, 16, cycles test_en is held high (>=1)
BASE_ADDR, 32'h0000_0000, byte address of first instruction word

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin/restart the boot sequence
ld_valid  in  1  boot source word valid
ld_data  in  32  boot source instruction word
ld_ready  out  1  sequencer accepts ld_data this cycle
imem_we  out  1  imem write strobe to the core
imem_waddr  out  32  imem byte write address
imem_wdata  out  32  imem write data
loader_done  out  1  to core loader_done_in; image valid
test_en  out  1  to core test_en_in; BIST window active
core_rst  out  1  synchronous reset to the pipeline core
mux_error_flag  in  1  core sticky mux fault
hardware_fault_flag  in  1  core sticky ALU/parity fault
busy  out  1  sequence in progress (LOAD or BIST)
fault  out  1  BIST failed
fault_code  out  2  01 = mux, 10 = hardware, 11 = both, 00 = none
state  out  3  debug encoding: IDLE=0, LOAD=1, BIST=2, RUN=3, FAULT=4

Behaviour:
- All outputs are registered except ld_ready, which is asserted exactly when state==LOAD.
- Reset (rst high at a clk edge):
  - state=IDLE, core_rst=1, and all other outputs 0; word and BIST counters cleared.
  - Takes priority over every event. Mid-LOAD or mid-BIST, the next edge returns to IDLE and drops imem_we and test_en; no partial-write completion.
- IDLE:
  - core_rst=1.
  - start -> LOAD; word index=0, fault/fault_code cleared.
- LOAD:
  - Each cycle with ld_valid and ld_ready is an accept. On the next edge: imem_we=1, imem_waddr=BASE_ADDR+4*idx, imem_wdata=ld_data, and idx increments. Latency is 1 cycle.
  - Cycles without an accept give imem_we=0 with waddr/wdata held.
  - ld_valid while ld_ready is low is ignored; no data is captured.
  - The accept at idx==PROG_WORDS-1 moves to BIST on the same edge, so ld_ready is low the following cycle. That cycle carries the final imem_we pulse.
  - imem_waddr wraps mod 2^32.
- BIST:
  - Cycle 0 after entry is a settle cycle with test_en=0.
  - test_en is then 1 for exactly BIST_CYCLES cycles. core_rst stays 1.
  - test_en never overlaps an imem_we pulse.
  - Any cycle where test_en==1 and (mux_error_flag or hardware_fault_flag): next edge goes to FAULT. test_en=0, fault=1, fault_code={hardware_fault_flag, mux_error_flag} as sampled.
  - Otherwise, after the last BIST cycle the next edge goes to RUN.
- RUN:
  - test_en=0, loader_done=1, core_rst=0.
  - Flags are ignored and start is ignored.
  - Only rst leaves RUN.
- FAULT:
  - core_rst=1, loader_done=0, fault/fault_code held.
  - start -> LOAD with a full reload and fault cleared; simultaneous flags are ignored.
- busy=1 in LOAD and BIST only.
- start is ignored in LOAD, BIST and RUN.
- Every output changes only on the clk edge following its cause.

Test Plan:
- PROG_WORDS=4, BIST_CYCLES=3, BASE_ADDR=0x100. rst, start, 4 back-to-back words 0xA0..0xA3 -> imem_we pulses on 4 consecutive cycles at 0x100/0x104/0x108/0x10C with matching data. One settle cycle, test_en high 3 cycles, then loader_done=1, core_rst=0, state=3.
- ld_valid toggling 1/0 with a word presented while state==IDLE -> IDLE word not written. Gaps give imem_we=0. Addresses stay contiguous; exactly 4 writes.
- mux_error_flag=1 in BIST cycle 2 -> next edge state=4, fault=1, fault_code=01, test_en=0, core_rst=1, loader_done=0. Then start -> LOAD, fault=0, full 4-word reload.
- Both flags high during BIST -> fault_code=11. A flag high only in the settle cycle (test_en=0) -> no fault, reaches RUN.
- rst asserted after 2 of 4 words accepted -> next edge state=0, imem_we=0, core_rst=1. A subsequent start restarts at 0x100.
- In RUN, start pulses and hardware_fault_flag=1 -> state stays 3, loader_done stays 1, no imem_we activity.

Source files
------------

// File: rtl/imem_boot_bist_sequencer.sv
// rtl/imem_boot_bist_sequencer.sv - power-on image loader and BIST sequencer for the ECC pipeline core
//
// Streams PROG_WORDS instruction words from the boot source into imem, runs a
// BIST window of BIST_CYCLES with test_en high, then releases the core from
// reset or parks in FAULT with the sampled fault flags.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                single-cycle request to begin/restart the boot sequence
//   ld_valid/ld_data     boot source word; ld_ready accepts it (combinational, LOAD only)
//   imem_we/waddr/wdata  registered imem write port to the core
//   loader_done          image valid, core may fetch (RUN only)
//   test_en              BIST window active
//   core_rst             synchronous reset held on the core until RUN
//   mux_error_flag       core sticky mux fault
//   hardware_fault_flag  core sticky ALU/parity fault
//   busy                 LOAD or BIST in progress
//   fault, fault_code    BIST result, fault_code = {hardware, mux}
//   state                debug state encoding
module imem_boot_bist_sequencer #(
  parameter int unsigned PROG_WORDS  = 64,
  parameter int unsigned BIST_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        loader_done,
  output logic        test_en,
  output logic        core_rst,
  input  logic        mux_error_flag,
  input  logic        hardware_fault_flag,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [2:0]  state
);

  localparam int unsigned IDX_W = (PROG_WORDS > 1) ? $clog2(PROG_WORDS) : 1;
  localparam int unsigned BC_W  = $clog2(BIST_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PROG_WORDS - 1);
  localparam logic [BC_W-1:0]  LAST_BC  = BC_W'(BIST_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_BIST  = 3'd2,
    S_RUN   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BC_W-1:0]  bc_q, bc_d;
  logic             we_d, te_d, fault_d, busy_d, done_d, core_rst_d;
  logic [31:0]      waddr_d, wdata_d;
  logic [1:0]       code_d;

  assign ld_ready = (state_q == S_LOAD);
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      bc_q        <= '0;
      imem_we     <= 1'b0;
      imem_waddr  <= 32'h0;
      imem_wdata  <= 32'h0;
      test_en     <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'b00;
      busy        <= 1'b0;
      loader_done <= 1'b0;
      core_rst    <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bc_q        <= bc_d;
      imem_we     <= we_d;
      imem_waddr  <= waddr_d;
      imem_wdata  <= wdata_d;
      test_en     <= te_d;
      fault       <= fault_d;
      fault_code  <= code_d;
      busy        <= busy_d;
      loader_done <= done_d;
      core_rst    <= core_rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bc_d    = bc_q;
    we_d    = 1'b0;
    waddr_d = imem_waddr;
    wdata_d = imem_wdata;
    te_d    = 1'b0;
    fault_d = fault;
    code_d  = fault_code;

    case (state_q)
      S_IDLE, S_FAULT: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          fault_d = 1'b0;
          code_d  = 2'b00;
        end
      end

      S_LOAD: begin
        if (ld_valid) begin
          we_d    = 1'b1;
          waddr_d = BASE_ADDR + (32'(idx_q) << 2);
          wdata_d = ld_data;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            // The first BIST cycle carries this final write, so it doubles as
            // the settle cycle with test_en low.
            state_d = S_BIST;
            idx_d   = '0;
            bc_d    = '0;
          end
        end
      end

      S_BIST: begin
        // Flags only count while the registered test_en is actually high.
        if (test_en && (mux_error_flag || hardware_fault_flag)) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = {hardware_fault_flag, mux_error_flag};
        end else if (bc_q == LAST_BC) begin
          state_d = S_RUN;
        end else begin
          bc_d = bc_q + 1'b1;
          te_d = 1'b1;
        end
      end

      S_RUN: begin
        state_d = S_RUN;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d == S_LOAD) || (state_d == S_BIST);
    done_d     = (state_d == S_RUN);
    core_rst_d = (state_d != S_RUN);
  end

endmodule

// File: tb/tb_imem_boot_bist_sequencer.sv
// tb/tb_imem_boot_bist_sequencer.sv - directed self-checking bench for imem_boot_bist_sequencer
module tb_imem_boot_bist_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        loader_done;
  logic        test_en;
  logic        core_rst;
  logic        mux_error_flag;
  logic        hardware_fault_flag;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_code;
  logic [2:0]  state;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  imem_boot_bist_sequencer #(
    .PROG_WORDS (4),
    .BIST_CYCLES(3),
    .BASE_ADDR  (32'h0000_0100)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .ld_valid           (ld_valid),
    .ld_data            (ld_data),
    .ld_ready           (ld_ready),
    .imem_we            (imem_we),
    .imem_waddr         (imem_waddr),
    .imem_wdata         (imem_wdata),
    .loader_done        (loader_done),
    .test_en            (test_en),
    .core_rst           (core_rst),
    .mux_error_flag     (mux_error_flag),
    .hardware_fault_flag(hardware_fault_flag),
    .busy               (busy),
    .fault              (fault),
    .fault_code         (fault_code),
    .state              (state)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE/FAULT: pulse start, land in LOAD.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_vec("start_state", 32'(state), 32'd1);
    check_vec("start_ready", 32'(ld_ready), 32'd1);
    check_vec("start_fault", 32'(fault), 32'd0);
  endtask

  // Four back-to-back words from LOAD; ends in the BIST settle cycle.
  task automatic do_load(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = base + 32'(i);
      tick();
      check_vec("ld_we", 32'(imem_we), 32'd1);
      check_vec("ld_addr", imem_waddr, 32'h100 + 32'(4 * i));
      check_vec("ld_data", imem_wdata, base + 32'(i));
    end
    ld_valid = 1'b0;
    check_vec("settle_state", 32'(state), 32'd2);
    check_vec("settle_ready", 32'(ld_ready), 32'd0);
    check_vec("settle_te", 32'(test_en), 32'd0);
    check_vec("settle_busy", 32'(busy), 32'd1);
  endtask

  // Runs until BIST is left, counting test_en cycles; bounded.
  task automatic bist_wait(input int exp_te, input logic [2:0] exp_state);
    int te_cnt = 0;
    int we_cnt = 0;
    for (int n = 0; n < 12 && state == 3'd2; n++) begin
      if (test_en) te_cnt++;
      if (imem_we && test_en) we_cnt++;
      tick();
    end
    check_vec("bist_end_state", 32'(state), 32'(exp_state));
    check_vec("bist_te_cycles", 32'(te_cnt), 32'(exp_te));
    check_vec("bist_we_overlap", 32'(we_cnt), 32'd0);
  endtask

  task automatic check_run();
    check_vec("run_state", 32'(state), 32'd3);
    check_vec("run_done", 32'(loader_done), 32'd1);
    check_vec("run_core_rst", 32'(core_rst), 32'd0);
    check_vec("run_te", 32'(test_en), 32'd0);
    check_vec("run_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_cnt;
    logic [31:0] last_addr;

    rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = 32'h0;
    mux_error_flag = 1'b0; hardware_fault_flag = 1'b0;
    tick();
    rst = 1'b0;

    // Reset state
    check_vec("rst_state", 32'(state), 32'd0);
    check_vec("rst_core_rst", 32'(core_rst), 32'd1);
    check_vec("rst_we", 32'(imem_we), 32'd0);
    check_vec("rst_te", 32'(test_en), 32'd0);
    check_vec("rst_done", 32'(loader_done), 32'd0);
    check_vec("rst_busy", 32'(busy), 32'd0);
    check_vec("rst_fault", 32'(fault), 32'd0);
    check_vec("rst_ready", 32'(ld_ready), 32'd0);

    // Basic boot to RUN
    do_start();
    do_load(32'hA0);
    bist_wait(3, 3'd3);
    check_run();

    // RUN ignores start and flags
    for (int i = 0; i < 4; i++) begin
      start = (i % 2 == 0);
      hardware_fault_flag = 1'b1;
      ld_valid = 1'b1;
      tick();
      check_vec("run_hold_state", 32'(state), 32'd3);
      check_vec("run_hold_done", 32'(loader_done), 32'd1);
      check_vec("run_hold_we", 32'(imem_we), 32'd0);
    end
    start = 1'b0; hardware_fault_flag = 1'b0; ld_valid = 1'b0;

    // IDLE word ignored, then gapped load
    do_reset();
    ld_valid = 1'b1; ld_data = 32'hDEAD;
    tick();
    check_vec("idle_we", 32'(imem_we), 32'd0);
    check_vec("idle_state", 32'(state), 32'd0);
    start = 1'b1; ld_data = 32'hBEEF;
    tick();
    start = 1'b0;
    check_vec("idle_start_we", 32'(imem_we), 32'd0);
    wr_cnt = 0;
    last_addr = imem_waddr;
    for (int i = 0; i < 7; i++) begin
      ld_valid = (i % 2 == 0);
      ld_data  = (i % 2 == 0) ? 32'hB0 + 32'(i / 2) : 32'hFFFF;
      tick();
      if (i % 2 == 0) begin
        wr_cnt++;
        check_vec("gap_we", 32'(imem_we), 32'd1);
        check_vec("gap_addr", imem_waddr, 32'h100 + 32'(4 * (i / 2)));
        check_vec("gap_data", imem_wdata, 32'hB0 + 32'(i / 2));
        last_addr = imem_waddr;
      end else begin
        check_vec("gap_idle_we", 32'(imem_we), 32'd0);
        check_vec("gap_addr_hold", imem_waddr, last_addr);
      end
    end
    ld_valid = 1'b0;
    check_vec("gap_writes", 32'(wr_cnt), 32'd4);
    check_vec("gap_settle_state", 32'(state), 32'd2);
    bist_wait(3, 3'd3);
    check_run();

    // Mux fault in test_en cycle 2, then restart
    do_reset();
    do_start();
    do_load(32'hC0);
    tick();
    check_vec("te_c1", 32'(test_en), 32'd1);
    tick();
    check_vec("te_c2", 32'(test_en), 32'd1);
    mux_error_flag = 1'b1;
    tick();
    mux_error_flag = 1'b0;
    check_vec("mf_state", 32'(state), 32'd4);
    check_vec("mf_fault", 32'(fault), 32'd1);
    check_vec("mf_code", 32'(fault_code), 32'd1);
    check_vec("mf_te", 32'(test_en), 32'd0);
    check_vec("mf_core_rst", 32'(core_rst), 32'd1);
    check_vec("mf_done", 32'(loader_done), 32'd0);
    check_vec("mf_busy", 32'(busy), 32'd0);
    tick();
    check_vec("mf_hold_state", 32'(state), 32'd4);
    check_vec("mf_hold_code", 32'(fault_code), 32'd1);
    mux_error_flag = 1'b1;
    do_start();
    mux_error_flag = 1'b0;
    check_vec("mf_restart_code", 32'(fault_code), 32'd0);
    do_load(32'hD0);
    bist_wait(3, 3'd3);
    check_run();

    // Flags in settle cycle only -> no fault
    do_reset();
    do_start();
    do_load(32'hE0);
    mux_error_flag = 1'b1; hardware_fault_flag = 1'b1;
    tick();
    mux_error_flag = 1'b0; hardware_fault_flag = 1'b0;
    check_vec("settle_flag_state", 32'(state), 32'd2);
    check_vec("settle_flag_fault", 32'(fault), 32'd0);
    bist_wait(3, 3'd3);
    check_run();

    // Both flags during test_en -> code 11
    do_reset();
    do_start();
    do_load(32'hF0);
    tick();
    mux_error_flag = 1'b1; hardware_fault_flag = 1'b1;
    tick();
    mux_error_flag = 1'b0; hardware_fault_flag = 1'b0;
    check_vec("both_state", 32'(state), 32'd4);
    check_vec("both_code", 32'(fault_code), 32'd3);
    check_vec("both_fault", 32'(fault), 32'd1);

    // Reset mid-load after 2 words, then restart from base
    do_reset();
    do_start();
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h50 + 32'(i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ld_valid = 1'b0;
    check_vec("midrst_state", 32'(state), 32'd0);
    check_vec("midrst_we", 32'(imem_we), 32'd0);
    check_vec("midrst_core_rst", 32'(core_rst), 32'd1);
    check_vec("midrst_ready", 32'(ld_ready), 32'd0);
    do_start();
    do_load(32'h60);
    bist_wait(3, 3'd3);
    check_run();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
